// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the Gray-code converter sweep controller.
package gray_conv_pkg;

  localparam int              CODE_W    = 4;
  localparam logic [3:0]      LAST_CODE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD,
    ST_DONE
  } state_e;

  // Reference decode: each binary bit is the running XOR of the Gray bits above it.
  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

endpackage

// File: rtl/gray_conv_checker.sv
// Compares a captured converter output against the Gray-to-binary reference.
module gray_conv_checker
  import gray_conv_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic [CODE_W-1:0] conv_out,
  input  logic              capture,
  output logic              mismatch
);

  assign mismatch = capture && (conv_out != gray2bin(code));

endmodule

// File: rtl/gray_conv_sweep_ctrl.sv
// Drives codes into the 4-bit converter, waits SETTLE_CYC cycles, captures results onto a valid/ready stream.
// Optional mismatch counting against the Gray reference is built only when GRAY_CHECK_EN is defined.
module gray_conv_sweep_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int CODE_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              single,
  input  logic [CODE_W-1:0] code_in,
  input  logic              abort,
  output logic [CODE_W-1:0] conv_in,
  input  logic [CODE_W-1:0] conv_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CODE_W-1:0] res_code,
  output logic [CODE_W-1:0] res_value,
  output logic              busy,
  output logic              done,
  output logic [4:0]        err_count
);
  import gray_conv_pkg::*;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [4:0] ERR_MAX     = 5'd31;

  state_e            state_q,     state_d;
  logic [CODE_W-1:0] code_q,      code_d;
  logic [CODE_W-1:0] conv_in_q,   conv_in_d;
  logic [CODE_W-1:0] res_code_q,  res_code_d;
  logic [CODE_W-1:0] res_value_q, res_value_d;
  logic [3:0]        settle_q,    settle_d;
  logic [4:0]        err_q,       err_d;
  logic              single_q,    single_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              mismatch;

`ifdef GRAY_CHECK_EN
  gray_conv_checker u_checker (
    .code     (code_q),
    .conv_out (conv_out),
    .capture  (state_q == ST_CAPTURE),
    .mismatch (mismatch)
  );
`else
  assign mismatch = 1'b0;
`endif

  // Abort overrides every transition but leaves the data-side registers untouched.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    conv_in_d   = conv_in_q;
    res_code_d  = res_code_q;
    res_value_d = res_value_q;
    settle_d    = settle_q;
    err_d       = err_q;
    single_d    = single_q;
    res_valid_d = res_valid_q;
    done_d      = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            single_d = single;
            code_d   = single ? code_in : '0;
            err_d    = '0;
            state_d  = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          conv_in_d = code_q;
          settle_d  = SETTLE_LOAD;
          state_d   = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == 4'd0) state_d = ST_CAPTURE;
          else                  settle_d = settle_q - 4'd1;
        end
        ST_CAPTURE: begin
          res_value_d = conv_out;
          res_code_d  = code_q;
          res_valid_d = 1'b1;
          if (mismatch && (err_q != ERR_MAX)) err_d = err_q + 5'd1;
          state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            if (single_q || (code_q == LAST_CODE)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              code_d  = code_q + 1'b1;
              state_d = ST_DRIVE;
            end
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      conv_in_q   <= '0;
      res_code_q  <= '0;
      res_value_q <= '0;
      settle_q    <= '0;
      err_q       <= '0;
      single_q    <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      conv_in_q   <= conv_in_d;
      res_code_q  <= res_code_d;
      res_value_q <= res_value_d;
      settle_q    <= settle_d;
      err_q       <= err_d;
      single_q    <= single_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign conv_in   = conv_in_q;
  assign res_valid = res_valid_q;
  assign res_code  = res_code_q;
  assign res_value = res_value_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gray_conv_sweep_ctrl.sv
// Self-checking bench for gray_conv_sweep_ctrl with a modelled Gray-to-binary converter.
module tb_gray_conv_sweep_ctrl;

  localparam int SETTLE = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       single;
  logic [3:0] code_in;
  logic       abort;
  logic [3:0] conv_in;
  logic [3:0] conv_out;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_code;
  logic [3:0] res_value;
  logic       busy;
  logic       done;
  logic [4:0] err_count;
  logic [3:0] convMask;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] code;
    logic [3:0] expValue;
  } vec_t;

  vec_t vecs [6];

  gray_conv_sweep_ctrl #(.SETTLE_CYC(SETTLE), .CODE_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .single    (single),
    .code_in   (code_in),
    .abort     (abort),
    .conv_in   (conv_in),
    .conv_out  (conv_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_code  (res_code),
    .res_value (res_value),
    .busy      (busy),
    .done      (done),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Binary value of a Gray code: XOR of the code with all of its right shifts.
  function automatic logic [3:0] refBin(input logic [3:0] g);
    logic [3:0] b;
    b = g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    return b;
  endfunction

  always_comb conv_out = refBin(conv_in) & convMask;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst conv_in",   int'(conv_in),   0);
    checkOutput("rst res_valid", int'(res_valid), 0);
    checkOutput("rst res_code",  int'(res_code),  0);
    checkOutput("rst res_value", int'(res_value), 0);
    checkOutput("rst busy",      int'(busy),      0);
    checkOutput("rst done",      int'(done),      0);
    checkOutput("rst err_count", int'(err_count), 0);
  endtask

  // Single conversion: latency, captured value, handshake, done pulse, return to idle.
  task automatic applyStimulus(input logic [3:0] code, input logic [3:0] expValue);
    int lat;
    @(negedge clk);
    start = 1'b1; single = 1'b1; code_in = code; res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; code_in = 4'($urandom);
    checkOutput("single busy", int'(busy), 1);
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("single latency",   lat,              SETTLE + 2);
    checkOutput("single res_value", int'(res_value),  int'(expValue));
    checkOutput("single res_code",  int'(res_code),   int'(code));
    checkOutput("single conv_in",   int'(conv_in),    int'(code));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("single valid drop", int'(res_valid), 0);
    checkOutput("single done",       int'(done),      1);
    @(negedge clk);
    checkOutput("single done width", int'(done), 0);
    checkOutput("single idle",       int'(busy), 0);
  endtask

  // Full 0..15 sweep with a scoreboard of the expected code order.
  task automatic runSweep(input bit randReady, input int stallCode, input bit randStart);
    int expCode, results, dones, cyc, stall, expErr, expCyc;
    bit pendingHold;
    logic [3:0] lastCode, lastVal;
    expCode = 0; results = 0; dones = 0; cyc = 0; stall = 0; expErr = 0;
    pendingHold = 1'b0; lastCode = '0; lastVal = '0;
    for (int i = 0; i < 16; i++)
      if ((refBin(4'(i)) & convMask) != refBin(4'(i))) expErr++;
`ifndef GRAY_CHECK_EN
    expErr = 0;
`endif
    expCyc = 16 * (SETTLE + 3) + ((stallCode >= 0 && stallCode < 16) ? 10 : 0);
    @(negedge clk);
    start = 1'b1; single = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 3000) begin
      if (done) begin
        dones++;
        start = 1'b0;
        checkOutput("sweep results at done", results, 16);
        break;
      end
      checkOutput("sweep busy", int'(busy), 1);
      if (res_valid) begin
        if (pendingHold) begin
          checkOutput("hold res_code",  int'(res_code),  int'(lastCode));
          checkOutput("hold res_value", int'(res_value), int'(lastVal));
          checkOutput("hold conv_in",   int'(conv_in),   int'(lastCode));
        end else begin
          checkOutput("sweep res_code",  int'(res_code),  expCode);
          checkOutput("sweep res_value", int'(res_value), int'(refBin(4'(expCode)) & convMask));
          checkOutput("sweep conv_in",   int'(conv_in),   expCode);
        end
        lastCode = res_code; lastVal = res_value;
        if (expCode == stallCode && stall < 10) begin
          res_ready = 1'b0;
          stall++;
        end else begin
          res_ready = randReady ? 1'($urandom) : 1'b1;
        end
        pendingHold = !res_ready;
        if (res_ready) begin
          results++;
          expCode++;
        end
      end else begin
        if (pendingHold) checkOutput("hold valid kept", 0, 1);
        pendingHold = 1'b0;
        res_ready = randReady ? 1'($urandom) : 1'b1;
      end
      if (randStart) begin
        start = 1'($urandom); single = 1'($urandom); code_in = 4'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checkOutput("sweep done seen", dones, 1);
    if (!randReady) checkOutput("sweep cycles", cyc, expCyc);
    checkOutput("sweep err_count", int'(err_count), expErr);
    @(negedge clk);
    checkOutput("sweep done width", int'(done), 0);
    checkOutput("sweep idle",       int'(busy), 0);
  endtask

  initial begin
    int cyc, doneCount;
    vecs[0] = '{code: 4'b0110, expValue: 4'b0100};
    vecs[1] = '{code: 4'b1101, expValue: 4'b1001};
    vecs[2] = '{code: 4'b0000, expValue: 4'b0000};
    vecs[3] = '{code: 4'b1111, expValue: 4'b1010};
    vecs[4] = '{code: 4'b1000, expValue: 4'b1111};
    vecs[5] = '{code: 4'b0011, expValue: 4'b0010};

    rst_n = 1'b0; start = 1'b0; single = 1'b0; code_in = '0;
    abort = 1'b0; res_ready = 1'b0; convMask = 4'hF;
    #12;
    checkReset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i].code, vecs[i].expValue);

    $display("[TB] sweep, ready tied high");
    runSweep(1'b0, -1, 1'b0);
    $display("[TB] sweep, backpressure on code 5");
    runSweep(1'b0, 5, 1'b0);
    $display("[TB] sweep, random ready and ignored starts");
    runSweep(1'b1, -1, 1'b1);

    $display("[TB] abort in SETTLE on code 7");
    @(negedge clk);
    start = 1'b1; single = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (conv_in != 4'd7 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("abort code 7 timing", cyc, 7 * (SETTLE + 3) + 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort busy",      int'(busy),      0);
    checkOutput("abort res_valid", int'(res_valid), 0);
    checkOutput("abort done",      int'(done),      0);
    checkOutput("abort conv_in",   int'(conv_in),   7);
    checkOutput("abort res_code",  int'(res_code),  6);
    checkOutput("abort res_value", int'(res_value), int'(refBin(4'd6)));
    doneCount = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("abort no done", doneCount, 0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("start+abort idle", int'(busy), 0);
    runSweep(1'b0, -1, 1'b0);

    $display("[TB] sweep, converter Z stuck at 0");
    convMask = 4'b1110;
    runSweep(1'b1, -1, 1'b0);
    convMask = 4'hF;

    $display("[TB] async reset in HOLD");
    @(negedge clk);
    start = 1'b1; single = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(res_valid && res_code == 4'd3) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    res_ready = 1'b0;
    checkOutput("pre-reset busy",  int'(busy),    1);
    checkOutput("pre-reset code",  int'(conv_in), 3);
    #2 rst_n = 1'b0;
    #1 checkReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkReset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_conv_sweep_ctrl.md
Name: gray_conv_sweep_ctrl

Overview:
Sequencer for the 4-bit combinational code converter (inputs A..D, outputs W..Z). It drives input codes into the converter, waits a settle interval, and captures each result. Results go out on a valid/ready stream. It supports a full 0..15 sweep or a single-code conversion, so the converter can be exercised on-chip without a hand-written stimulus sequence.

Parameters:
SETTLE_CYC, 2, cycles held between driving conv_in and sampling conv_out; legal range 1..15
CODE_W, 4, converter code width; fixed at 4 for this converter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin an operation; sampled in IDLE only
single  in  1  sampled with start: 1 = convert code_in once; 0 = sweep 0..15
code_in  in  4  code used when single=1
abort  in  1  synchronous abort; return to IDLE on next edge
conv_in  out  4  to converter: [3]=A (MSB), [2]=B, [1]=C, [0]=D
conv_out  in  4  from converter: [3]=W, [2]=X, [1]=Y, [0]=Z
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_code  out  4  code that produced res_value
res_value  out  4  captured conv_out
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of operation
err_count  out  5  mismatch count (see Optional Feature)

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - state=IDLE; conv_in=0, res_valid=0, res_code=0, res_value=0, busy=0, done=0, err_count=0.
  - Internal code counter and settle counter are 0.
- FSM states: IDLE, DRIVE, SETTLE, CAPTURE, HOLD, DONE.
- IDLE: on start=1:
  - Latch single.
  - Load the code counter with code_in if single=1, else with 0.
  - Clear err_count, then go to DRIVE.
- DRIVE (1 cycle): conv_in <= code; settle counter <= SETTLE_CYC-1; go to SETTLE.
- SETTLE: decrement the counter each cycle; when the counter is 0, go to CAPTURE. This state lasts exactly SETTLE_CYC cycles.
- CAPTURE (1 cycle): res_value <= conv_out, res_code <= code, res_valid <= 1; go to HOLD.
- HOLD: wait for res_ready.
  - res_value and res_code stay stable while res_valid=1 and res_ready=0.
  - On an edge with res_valid & res_ready: res_valid <= 0.
  - If single, or if code==15: go to DONE.
  - Otherwise: code <= code+1, go to DRIVE.
- DONE: done=1 for exactly one cycle; go to IDLE. conv_in holds its last value.
- Latency:
  - res_valid rises SETTLE_CYC+2 edges after the edge that samples start.
  - Steady-state period is SETTLE_CYC+3 cycles per code with res_ready tied high.
  - A full sweep is 16 results, 80 cycles at default settings.
- The code counter never wraps during a sweep; 15 is terminal.
- start is ignored while busy=1.
- abort has priority over every transition:
  - On the next edge: state=IDLE, res_valid=0, done stays 0.
  - conv_in, res_code, res_value and err_count keep their values.
- start and abort high together in IDLE: abort wins, so the operation does not start.
- Asynchronous reset mid-operation forces all reset values immediately.

Optional Feature:
GRAY_CHECK_EN
- Defined:
  - In CAPTURE, compare conv_out with the Gray-to-binary reference of code: b3=g3, b2=b3^g2, b1=b2^g1, b0=b1^g0.
  - Increment err_count on mismatch; it saturates at 31 and is cleared on start.
- Not defined: err_count is tied to 0 and the comparator is not built. The port list is unchanged.

Decomposition:
- Package gray_conv_pkg holds:
  - the FSM state enum typedef;
  - CODE_W and LAST_CODE=4'hF;
  - the function gray2bin(logic [3:0]).
- The FSM, counters and result registers live in one module.
- The optional checker is a natural sub-module, gray_conv_checker: inputs code, conv_out and a capture strobe; output a mismatch pulse.

Test Plan:
- Sweep, res_ready=1, true Gray converter, SETTLE_CYC=2: 16 results with res_code 0..15 and res_value=gray2bin(code), e.g. code 4'b1101 gives 4'b1001. done pulses once at cycle 80; err_count=0.
- single=1, code_in=4'b0110: exactly one result with res_value=4'b0100. res_valid rises 4 edges after start, then done, then IDLE.
- Backpressure: hold res_ready=0 for 10 cycles on code 5. res_valid stays 1, res_code and res_value stay stable, conv_in stays 5, and no code is skipped.
- abort asserted in SETTLE on code 7: IDLE next edge, res_valid=0, no done pulse. A following start runs a full sweep from 0.
- GRAY_CHECK_EN with converter output bit Z stuck at 0: err_count=8 at done, one count per code whose expected b0 is 1.
- rst_n low mid-sweep in HOLD: all outputs take reset values immediately, without a clock edge.
